// File: rtl/mux4_1_rr_collector.sv
// 4-to-1 round-robin stream collector with burst-locked grants and one registered output stage.
// Each output beat carries the index of the lane it came from.

module mux4_1_rr_lane #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [1:0] LANE       = 2'd0
) (
  input  logic                  sel_en_i,
  input  logic [1:0]            grant_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  take_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  // Ready depends only on FSM/output-slot state, never on valid.
  assign ready_o = sel_en_i && (grant_i == LANE);
  assign take_o  = ready_o && valid_i;
  // Masked data lets the top OR-reduce lanes instead of building a wide mux.
  assign data_o  = take_o ? data_i : '0;
endmodule

module mux4_1_rr_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  input  logic [3:0]              in_valid,
  output logic [3:0]              in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [1:0]             out_sel_q, out_sel_d;
  logic                   out_valid_q, out_valid_d;

  logic                                   can_load;
  logic                                   sel_en;
  logic                                   accept;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   lane_data;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   lane_masked;
  logic [NUM_LANES-1:0]                   lane_take;
  logic [DATA_WIDTH-1:0]                  mux_data;
  logic                                   arb_found;
  logic [1:0]                             arb_lane;

  assign lane_data = in_data;
  assign can_load  = !out_valid_q || out_ready;
  assign sel_en    = can_load && (state_q == BURST);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mux4_1_rr_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE       (2'(g))
    ) u_lane (
      .sel_en_i (sel_en),
      .grant_i  (grant_q),
      .valid_i  (in_valid[g]),
      .data_i   (lane_data[g]),
      .ready_o  (in_ready[g]),
      .take_o   (lane_take[g]),
      .data_o   (lane_masked[g])
    );
  end

  assign accept = |lane_take;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_LANES; i++) mux_data = mux_data | lane_masked[i];
  end

  // Rotating priority search starting at rr_ptr; 2-bit index wraps naturally.
  always_comb begin
    arb_found = 1'b0;
    arb_lane  = rr_ptr_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!arb_found && in_valid[rr_ptr_q + 2'(k)]) begin
        arb_found = 1'b1;
        arb_lane  = rr_ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      out_data_d  = mux_data;
      out_sel_d   = grant_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d    = arb_lane;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // A stalled grant simply waits; producers are trusted to finish bursts.
        if (accept) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            rr_ptr_d   = grant_q + 2'd1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == BURST) || out_valid_q;

endmodule

// File: tb/tb_mux4_1_rr_collector.sv
// Directed bench for mux4_1_rr_collector: lane producers emit 8'h10*lane + n,
// a monitor logs every output handshake with its cycle number.

module tb_mux4_1_rr_collector;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] cnt [4];
  logic [9:0] bq [$];
  int         bt [$];

  mux4_1_rr_collector #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (reset) cnt[i] <= 8'd0;
      else if (in_valid[i] && in_ready[i]) cnt[i] <= cnt[i] + 8'd1;
    end
    if (!reset && out_valid && out_ready) begin
      bq.push_back({out_sel, out_data});
      bt.push_back(cyc);
    end
  end

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(8'h10 * i) + cnt[i];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k = 0;
    while (bq.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bq.size() < n) begin
      failures++;
      $display("FAIL %s timeout beats=%0d need=%0d", name, bq.size(), n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 4'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bq.delete(); bt.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_1clk_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("rel_2clk_out_valid", 32'(out_valid), 32'd1);
    chk("rel_2clk_out_sel", 32'(out_sel), 32'd0);
    chk("rel_2clk_out_data", 32'(out_data), 32'h00);
  endtask

  task automatic test_all_lanes();
    apply_reset();
    in_valid = 4'hF;
    wait_beats(16, 80, "all_lanes");
    in_valid = 4'h0;
    for (int k = 0; k < 16 && k < bq.size(); k++) begin
      chk($sformatf("all_sel[%0d]", k), 32'(bq[k][9:8]), 32'(k / 4));
      chk($sformatf("all_data[%0d]", k), 32'(bq[k][7:0]), 32'(8'h10 * (k / 4) + k % 4));
      if (k > 0)
        chk($sformatf("all_gap[%0d]", k), 32'(bt[k] - bt[k-1]), (k % 4 == 0) ? 32'd2 : 32'd1);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_valid = 4'b0001;
    wait_beats(2, 20, "bp_start");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h02);
      chk("bp_out_sel", 32'(out_sel), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_no_drain", 32'(bq.size()), 32'd2);
    out_ready = 1'b1;
    wait_beats(4, 20, "bp_resume");
    in_valid = 4'h0;
    for (int k = 0; k < 4 && k < bq.size(); k++) begin
      chk($sformatf("bp_sel[%0d]", k), 32'(bq[k][9:8]), 32'd0);
      chk($sformatf("bp_data[%0d]", k), 32'(bq[k][7:0]), 32'(k));
    end
    repeat (5) @(posedge clk);
    #1;
    chk("bp_beat_count", 32'(bq.size()), 32'd4);
  endtask

  task automatic test_fairness();
    apply_reset();
    in_valid = 4'b0101;
    wait_beats(16, 100, "fair");
    in_valid = 4'h0;
    for (int k = 0; k < 16 && k < bq.size(); k++) begin
      int b = k / 4;
      int lane = (b % 2 == 1) ? 2 : 0;
      chk($sformatf("fair_sel[%0d]", k), 32'(bq[k][9:8]), 32'(lane));
      chk($sformatf("fair_data[%0d]", k), 32'(bq[k][7:0]), 32'(8'h10 * lane + (b / 2) * 4 + k % 4));
    end
  endtask

  task automatic test_lane_stall();
    int k = 0;
    apply_reset();
    in_valid = 4'b1010;
    while (cnt[1] < 8'd2 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("stall_reach2", 32'(cnt[1]), 32'd2);
    in_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 32'b0010);
      chk("stall_lane3_cnt", 32'(cnt[3]), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    in_valid = 4'b1010;
    wait_beats(8, 40, "stall_resume");
    in_valid = 4'h0;
    for (int j = 0; j < 8 && j < bq.size(); j++) begin
      chk($sformatf("stall_sel[%0d]", j), 32'(bq[j][9:8]), (j < 4) ? 32'd1 : 32'd3);
      chk($sformatf("stall_data[%0d]", j), 32'(bq[j][7:0]),
          (j < 4) ? 32'(8'h10 + j) : 32'(8'h30 + j - 4));
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    in_valid = 4'hF;
    wait_beats(6, 40, "mid_start");
    chk("mid_pre_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    in_valid = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    bq.delete(); bt.delete();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("mid_no_held_beat", 32'(out_valid), 32'd0);
    end
    in_valid = 4'hF;
    wait_beats(1, 10, "mid_restart");
    in_valid = 4'h0;
    if (bq.size() > 0) begin
      chk("mid_restart_sel", 32'(bq[0][9:8]), 32'd0);
      chk("mid_restart_data", 32'(bq[0][7:0]), 32'h00);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 4'h0; out_ready = 1'b1;
    test_reset();
    test_all_lanes();
    test_backpressure();
    test_fairness();
    test_lane_stall();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
